fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the multi-cycle core. It owns the program-counter register, issues instruction-memory reads over a req/ack handshake, and presents each fetched word to decode/execute. On completion it accepts the next-PC value computed by the next-PC logic. It drives `cpc` into that logic and consumes its `npc` result, closing the PC loop.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `ACK_TIMEOUT`, default 255: maximum cycles in FETCH without `imem_ack` before error; legal range 1..255.
- `clk` in 1: single clock; all state on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: begin execution; honoured only in IDLE.
- `imem_addr` out 32: read address, equal to `cpc`.
- `imem_req` out 1: read request, level, high for the whole of FETCH.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `cpc` out 32: current PC, fed to next-PC logic.
- `inst` out 32: registered instruction for decode.
- `inst_valid` out 1: high for the whole of ISSUE.
- `exec_done` in 1: execute finished the current instruction; honoured only while `inst_valid`=1.
- `npc` in 32: next PC, sampled with `exec_done`.
- `halt` in 1: current instruction is a halt; sampled only with `exec_done`.
- `retired` out 32: count of honoured `exec_done` events.
- `halted` out 1: in HALT.
- `err` out 1: in ERR (sticky).
- `err_code` out 2: 00 none, 01 misaligned `npc`, 10 ack timeout.

## Operation
- States: IDLE, FETCH, ISSUE, HALT, ERR.
- IDLE: `start`=1 -> FETCH. PC stays at `RESET_PC`.
- FETCH: `imem_req`=1 and `imem_addr`=`cpc`.
  - `imem_ack`=1 -> capture `imem_rdata` into `inst`, clear the timeout counter, go to ISSUE.
  - An ack in the first FETCH cycle is legal.
- Timeout counter: 8 bits, counts FETCH cycles without ack. When the count reaches `ACK_TIMEOUT` -> ERR, `err_code`=10.
- Ack priority: if ack and timeout fall in the same cycle, the ack wins.
- ISSUE: `inst_valid`=1, `inst` held stable. On `exec_done`=1:
  - `retired` += 1 (wraps modulo 2^32).
  - `halt`=1 -> HALT; PC not updated.
  - else `npc[1:0]`≠00 -> ERR, `err_code`=01; PC not updated.
  - else PC <= `npc`, go to FETCH.
- `halt` has priority over the misalignment check.
- `exec_done` or `halt` outside ISSUE: ignored. `imem_ack` outside FETCH: ignored; `inst` unchanged.
- HALT and ERR are terminal. Only `rstn` leaves them. In both, `imem_req`=0 and `inst_valid`=0.
- Reset values: state IDLE; `cpc`/`imem_addr`=`RESET_PC`; `inst`=0; `imem_req`=0; `inst_valid`=0; `retired`=0; `halted`=0; `err`=0; `err_code`=00; timeout counter 0.
- Reset mid-FETCH drops `imem_req` asynchronously. Any memory response arriving after reset is ignored, because state is IDLE.

## Timing
- `start` at cycle t -> `imem_req`=1 at t+1.
- `imem_ack` at cycle u -> `inst_valid`=1 and `inst`=rdata(u) at u+1.
- Best-case start to `inst_valid` is 2 cycles.
- `exec_done` at cycle v -> `cpc`=`npc`(v) and `imem_req`=1 at v+1; `inst_valid`=0 at v+1.
- `retired`, `halted`, `err` and `err_code` update at v+1, or one cycle after the timeout condition.
- Timeout: with no ack, FETCH entered at cycle f gives ERR at f+`ACK_TIMEOUT`.
- All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

## Test plan
- Reset and start, memory acks in the first FETCH cycle with 32'h2001_0005 -> `imem_req` high for 1 cycle, `inst_valid` and `inst`=32'h2001_0005 two cycles after `start`, `cpc`=0.
- Sequential run: 3 instructions, `exec_done` with `npc`=4, 8, 12, ack delay 3 cycles -> `imem_addr` sequence 0, 4, 8, 12; `retired`=3; `inst_valid` never high during FETCH.
- Halt: `exec_done`=1, `halt`=1, `npc`=32'h0000_0003 -> `halted`=1, `err`=0, `cpc` unchanged, `retired` incremented, `imem_req` stays 0 for 10 cycles.
- Misaligned redirect: `exec_done` with `npc`=32'h0000_0102 -> `err`=1, `err_code`=01, `cpc` unchanged; a later `start` is ignored.
- Timeout with `ACK_TIMEOUT`=4: no ack -> ERR exactly 4 cycles after FETCH entry, `err_code`=10.
  - Repeat with ack in the 4th cycle -> ISSUE, no error.
- Async reset mid-FETCH, with `retired`=5 and `cpc`=32'h40: assert `rstn`=0 between edges -> `imem_req` falls immediately, `retired`=0, `cpc`=`RESET_PC`; an ack pulse during IDLE leaves `inst`=0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/ack handshake,
// presents each word to decode and takes the next PC when execute completes.
module fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_cpc,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    input  logic        i_exec_done,
    input  logic [31:0] i_npc,
    input  logic        i_halt,
    output logic [31:0] o_retired,
    output logic        o_halted,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StHalt,
        StErr
    } state_e;

    localparam logic [7:0] TimeoutLim = 8'(ACK_TIMEOUT);
    localparam logic [1:0] CodeMisalign = 2'b01;
    localparam logic [1:0] CodeTimeout  = 2'b10;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_retired;
    logic [31:0] w_retired_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_code_nxt;
    logic [7:0]  r_tmo_cnt;
    logic [7:0]  w_tmo_cnt_nxt;
    logic [7:0]  w_tmo_cnt_inc;

    assign w_tmo_cnt_inc = r_tmo_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_retired_nxt  = r_retired;
        w_err_code_nxt = r_err_code;
        w_tmo_cnt_nxt  = r_tmo_cnt;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt   = StFetch;
                    w_tmo_cnt_nxt = 8'd0;
                end
            end

            StFetch: begin
                // An ack arriving in the same cycle as the timeout still wins.
                if (i_imem_ack) begin
                    w_inst_nxt    = i_imem_rdata;
                    w_tmo_cnt_nxt = 8'd0;
                    w_state_nxt   = StIssue;
                end else if (w_tmo_cnt_inc == TimeoutLim) begin
                    w_tmo_cnt_nxt  = w_tmo_cnt_inc;
                    w_err_code_nxt = CodeTimeout;
                    w_state_nxt    = StErr;
                end else begin
                    w_tmo_cnt_nxt = w_tmo_cnt_inc;
                end
            end

            StIssue: begin
                if (i_exec_done) begin
                    w_retired_nxt = r_retired + 32'd1;
                    if (i_halt) begin
                        w_state_nxt = StHalt;
                    end else if (i_npc[1:0] != 2'b00) begin
                        w_err_code_nxt = CodeMisalign;
                        w_state_nxt    = StErr;
                    end else begin
                        w_pc_nxt      = i_npc;
                        w_tmo_cnt_nxt = 8'd0;
                        w_state_nxt   = StFetch;
                    end
                end
            end

            StHalt: begin
                w_state_nxt = StHalt;
            end

            StErr: begin
                w_state_nxt = StErr;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_retired  <= 32'd0;
            r_err_code <= 2'b00;
            r_tmo_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_retired  <= w_retired_nxt;
            r_err_code <= w_err_code_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
        end
    end

    // Handshake and status flags decode from state alone, so reset drops them at once.
    assign o_imem_req   = (r_state == StFetch);
    assign o_inst_valid = (r_state == StIssue);
    assign o_halted     = (r_state == StHalt);
    assign o_err        = (r_state == StErr);
    assign o_imem_addr  = r_pc;
    assign o_cpc        = r_pc;
    assign o_inst       = r_inst;
    assign o_retired    = r_retired;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed steps plus randomized runs, checked
// against a transaction-level model of PC, instruction, retire count and status.
module tb_fetch_controller;

    localparam logic [31:0] RstPc  = 32'h0000_0000;
    localparam int          Tmo    = 4;
    localparam logic [31:0] RstPcB = 32'h0000_1000;

    logic        clk;
    logic        i_rstn;
    logic        i_start;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_exec_done;
    logic [31:0] i_npc;
    logic        i_halt;

    logic [31:0] o_imem_addr;
    logic        o_imem_req;
    logic [31:0] o_cpc;
    logic [31:0] o_inst;
    logic        o_inst_valid;
    logic [31:0] o_retired;
    logic        o_halted;
    logic        o_err;
    logic [1:0]  o_err_code;

    logic [31:0] b_imem_addr;
    logic        b_imem_req;
    logic [31:0] b_cpc;
    logic [31:0] b_inst;
    logic        b_inst_valid;
    logic [31:0] b_retired;
    logic        b_halted;
    logic        b_err;
    logic [1:0]  b_err_code;

    fetch_controller #(
        .RESET_PC    (RstPc),
        .ACK_TIMEOUT (Tmo)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .o_imem_addr  (o_imem_addr),
        .o_imem_req   (o_imem_req),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_cpc        (o_cpc),
        .o_inst       (o_inst),
        .o_inst_valid (o_inst_valid),
        .i_exec_done  (i_exec_done),
        .i_npc        (i_npc),
        .i_halt       (i_halt),
        .o_retired    (o_retired),
        .o_halted     (o_halted),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    fetch_controller #(
        .RESET_PC    (RstPcB),
        .ACK_TIMEOUT (255)
    ) dut_b (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .o_imem_addr  (b_imem_addr),
        .o_imem_req   (b_imem_req),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_cpc        (b_cpc),
        .o_inst       (b_inst),
        .o_inst_valid (b_inst_valid),
        .i_exec_done  (i_exec_done),
        .i_npc        (i_npc),
        .i_halt       (i_halt),
        .o_retired    (b_retired),
        .o_halted     (b_halted),
        .o_err        (b_err),
        .o_err_code   (b_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err;
    int n_chk;

    // Reference model: architectural view only.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ret;
    logic        m_halted;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_req, input logic exp_valid);
        chk({tag, ".req"},      32'(o_imem_req),   32'(exp_req));
        chk({tag, ".valid"},    32'(o_inst_valid), 32'(exp_valid));
        chk({tag, ".halted"},   32'(o_halted),     32'(m_halted));
        chk({tag, ".err"},      32'(o_err),        32'(m_err));
        chk({tag, ".err_code"}, 32'(o_err_code),   32'(m_code));
        chk({tag, ".cpc"},      o_cpc,             m_pc);
        chk({tag, ".addr"},     o_imem_addr,       m_pc);
        chk({tag, ".inst"},     o_inst,            m_inst);
        chk({tag, ".retired"},  o_retired,         m_ret);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_start      = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'd0;
        i_exec_done  = 1'b0;
        i_npc        = 32'd0;
        i_halt       = 1'b0;
    endtask

    task automatic model_reset;
        m_pc     = RstPc;
        m_inst   = 32'd0;
        m_ret    = 32'd0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_code   = 2'b00;
    endtask

    task automatic do_reset;
        idle_inputs();
        i_rstn = 1'b0;
        model_reset();
        #1;
        chk_all("reset_async", 1'b0, 1'b0);
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0);
        chk("reset_b.cpc", b_cpc, RstPcB);
        chk("reset_b.addr", b_imem_addr, RstPcB);
        i_rstn = 1'b1;
    endtask

    task automatic do_start;
        chk_all("idle", 1'b0, 1'b0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_all("start", 1'b1, 1'b0);
    endtask

    // Entered in the first FETCH cycle; ack comes after 'delay' idle cycles.
    task automatic fetch(input int delay, input logic [31:0] word);
        for (int k = 0; k < delay; k++) begin
            chk_all("fetch_wait", 1'b1, 1'b0);
            i_imem_rdata = $urandom;
            i_exec_done  = 1'($urandom);
            i_halt       = 1'($urandom);
            i_npc        = $urandom;
            i_start      = 1'($urandom);
            tick();
        end
        chk_all("fetch_ack", 1'b1, 1'b0);
        i_imem_ack   = 1'b1;
        i_imem_rdata = word;
        tick();
        idle_inputs();
        m_inst = word;
        chk_all("issue", 1'b0, 1'b1);
    endtask

    task automatic execute(input int wait_c, input logic [31:0] npc, input logic hlt);
        logic aligned;
        for (int k = 0; k < wait_c; k++) begin
            chk_all("issue_wait", 1'b0, 1'b1);
            i_imem_ack   = 1'($urandom);
            i_imem_rdata = $urandom;
            i_start      = 1'($urandom);
            tick();
        end
        i_imem_ack   = 1'($urandom);
        i_imem_rdata = $urandom;
        i_exec_done  = 1'b1;
        i_npc        = npc;
        i_halt       = hlt;
        tick();
        idle_inputs();
        aligned = (npc[1:0] == 2'b00);
        m_ret = m_ret + 32'd1;
        if (hlt) begin
            m_halted = 1'b1;
        end else if (!aligned) begin
            m_err  = 1'b1;
            m_code = 2'b01;
        end else begin
            m_pc = npc;
        end
        chk_all("exec", !hlt && aligned, 1'b0);
    endtask

    task automatic timeout_run;
        for (int k = 0; k < Tmo; k++) begin
            chk_all("tmo_wait", 1'b1, 1'b0);
            i_imem_rdata = $urandom;
            tick();
        end
        m_err  = 1'b1;
        m_code = 2'b10;
        chk_all("tmo", 1'b0, 1'b0);
    endtask

    task automatic terminal_hold(input int n);
        for (int k = 0; k < n; k++) begin
            i_start      = 1'b1;
            i_imem_ack   = 1'($urandom);
            i_imem_rdata = $urandom;
            i_exec_done  = 1'($urandom);
            i_halt       = 1'($urandom);
            i_npc        = $urandom;
            tick();
            chk_all("hold", 1'b0, 1'b0);
        end
        idle_inputs();
    endtask

    function automatic logic [31:0] rand_aligned();
        logic [31:0] v;
        v = $urandom;
        v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        logic [31:0] n;
        int          kind;
        n_err = 0;
        n_chk = 0;
        idle_inputs();
        i_rstn = 1'b1;
        model_reset();
        tick();

        // Reset, start, ack in first FETCH cycle.
        do_reset();
        do_start();
        fetch(0, 32'h2001_0005);

        // Sequential run with 3-cycle ack delay.
        execute(1, 32'd4, 1'b0);
        fetch(3, $urandom);
        execute(0, 32'd8, 1'b0);
        fetch(3, $urandom);
        execute(2, 32'd12, 1'b0);
        chk("seq.retired", o_retired, 32'd3);
        fetch(3, $urandom);

        for (int i = 0; i < 20; i++) begin
            execute(int'($urandom_range(3, 0)), rand_aligned(), 1'b0);
            fetch(int'($urandom_range(Tmo - 1, 0)), $urandom);
        end

        // Halt wins over a misaligned npc.
        execute(1, 32'h0000_0003, 1'b1);
        terminal_hold(10);

        // Misaligned redirect; later start ignored.
        do_reset();
        do_start();
        fetch(1, $urandom);
        execute(0, 32'h0000_0102, 1'b0);
        terminal_hold(5);

        // Ack timeout, then ack in the last legal cycle.
        do_reset();
        do_start();
        timeout_run();
        terminal_hold(3);
        do_reset();
        do_start();
        fetch(Tmo - 1, $urandom);

        // Async reset in the middle of FETCH.
        do_reset();
        do_start();
        fetch(0, $urandom);
        execute(0, 32'h10, 1'b0);
        fetch(1, $urandom);
        execute(1, 32'h20, 1'b0);
        fetch(2, $urandom);
        execute(0, 32'h30, 1'b0);
        fetch(0, $urandom);
        execute(2, 32'h38, 1'b0);
        fetch(1, $urandom);
        execute(0, 32'h40, 1'b0);
        chk("pre_rst.retired", o_retired, 32'd5);
        chk("pre_rst.cpc", o_cpc, 32'h40);
        #2;
        i_rstn = 1'b0;
        model_reset();
        #1;
        chk_all("mid_fetch_rst", 1'b0, 1'b0);
        tick();
        i_rstn       = 1'b1;
        i_imem_ack   = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk_all("idle_ack", 1'b0, 1'b0);

        // Random episodes ending in a random terminal condition.
        for (int e = 0; e < 6; e++) begin
            do_reset();
            do_start();
            fetch(int'($urandom_range(Tmo - 1, 0)), $urandom);
            for (int i = 0; i < int'($urandom_range(5, 0)); i++) begin
                execute(int'($urandom_range(3, 0)), rand_aligned(), 1'b0);
                fetch(int'($urandom_range(Tmo - 1, 0)), $urandom);
            end
            kind = int'($urandom_range(2, 0));
            if (kind == 0) begin
                execute(int'($urandom_range(3, 0)), $urandom, 1'b1);
            end else if (kind == 1) begin
                n = $urandom;
                if (n[1:0] == 2'b00) n[0] = 1'b1;
                execute(int'($urandom_range(3, 0)), n, 1'b0);
            end else begin
                execute(int'($urandom_range(3, 0)), rand_aligned(), 1'b0);
                timeout_run();
            end
            terminal_hold(3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
